bus_hold_arbiter: RTL and testbench

BUS_HOLD_ARBITER -- requirements
Module: bus_hold_arbiter

---
 rtl/arb_pkg.sv | 17 +
 rtl/rr_pick2.sv | 12 +
 rtl/bus_hold_arbiter.sv | 118 +++++++++++
 tb/tb_bus_hold_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 8088 bus-hold arbiter: FSM states and counter sizing.
package arb_pkg;

  localparam int CNT_W         = 8;
  localparam int MAX_BURST_DEF = 16;

  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD_REQ,
    ST_GRANT,
    ST_REVOKE,
    ST_RELEASE
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not last granted.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       win_o,
  output logic       vld_o
);

  assign vld_o = |req_i;
  assign win_o = (req_i == 2'b11) ? ~ptr_i : req_i[1];

endmodule

// File: rtl/bus_hold_arbiter.sv
// Arbitrates two bus masters for the 8088 via HOLD/HLDA, with a burst limit that
// lets a waiting requester force the current owner off the bus.
module bus_hold_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [1:0] REQ,
  input  logic       HLDA,
  output logic       HOLD,
  output logic [1:0] GNT,
  output logic       OWNER,
  output logic       BUSY
);

  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

  arb_state_e       state_q;
  logic             hold_q;
  logic [1:0]       gnt_q;
  logic             owner_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             ptr_q;
  logic             win_q;
  logic             pick_win;
  logic             pick_vld;
  logic             burst_done;

  rr_pick2 u_pick (
    .req_i (REQ),
    .ptr_i (ptr_q),
    .win_o (pick_win),
    .vld_o (pick_vld)
  );

  assign cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
  // ">=" so a requester arriving after the limit was passed can still revoke.
  assign burst_done = (cnt_q >= BURST_LIM);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      hold_q  <= 1'b0;
      gnt_q   <= 2'b00;
      owner_q <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= 1'b1;
      win_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            win_q   <= pick_win;
            hold_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_HOLD_REQ;
          end
        end
        ST_HOLD_REQ: begin
          if (HLDA) begin
            if (REQ[win_q]) begin
              gnt_q   <= win_q ? 2'b10 : 2'b01;
              cnt_q   <= CNT_W'(1);
              ptr_q   <= win_q;
              owner_q <= win_q;
              state_q <= ST_GRANT;
            end else begin
              hold_q  <= 1'b0;
              state_q <= ST_RELEASE;
            end
          end
        end
        ST_GRANT: begin
          if (!REQ[owner_q]) begin
            gnt_q   <= 2'b00;
            hold_q  <= 1'b0;
            state_q <= ST_RELEASE;
          end else if (burst_done && REQ[~owner_q]) begin
            gnt_q   <= 2'b00;
            state_q <= ST_REVOKE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_REVOKE: begin
          // HOLD stays up so the CPU cannot slip in before the owner lets go.
          if (!REQ[owner_q]) begin
            hold_q  <= 1'b0;
            state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!HLDA) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          hold_q  <= 1'b0;
          gnt_q   <= 2'b00;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign HOLD  = hold_q;
  assign GNT   = gnt_q;
  assign OWNER = owner_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// requesters and a randomly slow 8088, all checked against a phase-level model.
module tb_bus_hold_arbiter;

  localparam int MB = 4;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [1:0] REQ = 2'b00;
  logic       HLDA = 1'b0;
  logic       HOLD;
  logic [1:0] GNT;
  logic       OWNER;
  logic       BUSY;

  int n_total = 0;
  int n_pass  = 0;

  bus_hold_arbiter #(.MAX_BURST(MB)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .REQ     (REQ),
    .HLDA    (HLDA),
    .HOLD    (HOLD),
    .GNT     (GNT),
    .OWNER   (OWNER),
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Model: 0 idle, 1 hold asked, 2 bus granted, 3 owner being evicted, 4 waiting for CPU.
  int m_phase = 0;
  int m_win   = 0;
  int m_owner = 0;
  int m_last  = 1;
  int m_burst = 0;
  int glen    = 0;

  function automatic void m_reset();
    m_phase = 0; m_win = 0; m_owner = 0; m_last = 1; m_burst = 0;
  endfunction

  function automatic void m_step(input logic [1:0] r, input logic h);
    case (m_phase)
      0: if (r != 2'b00) begin
           if (r == 2'b11) m_win = 1 - m_last;
           else            m_win = r[1] ? 1 : 0;
           m_phase = 1;
         end
      1: if (h) begin
           if (r[m_win]) begin
             m_owner = m_win; m_last = m_win; m_burst = 1; m_phase = 2;
           end else m_phase = 4;
         end
      2: if (!r[m_owner]) m_phase = 4;
         else if (m_burst >= MB && r[1 - m_owner]) m_phase = 3;
         else if (m_burst < 255) m_burst++;
      3: if (!r[m_owner]) m_phase = 4;
      4: if (!h) m_phase = 0;
      default: m_phase = 0;
    endcase
  endfunction

  function automatic int m_hold();  return (m_phase >= 1 && m_phase <= 3) ? 1 : 0; endfunction
  function automatic int m_busy();  return (m_phase != 0) ? 1 : 0; endfunction
  function automatic int m_gnt();   return (m_phase == 2) ? (1 << m_owner) : 0; endfunction

  logic [1:0] s_req;
  logic       s_hlda;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_reset();
      glen = 0;
    end else begin
      s_req  = REQ;
      s_hlda = HLDA;
      m_step(s_req, s_hlda);
      #1;
      chk("mon_hold",  int'(HOLD),  m_hold());
      chk("mon_gnt",   int'(GNT),   m_gnt());
      chk("mon_owner", int'(OWNER), m_owner);
      chk("mon_busy",  int'(BUSY),  m_busy());
      chk("inv_onehot", int'(GNT != 2'b11), 1);
      chk("inv_gnt_needs_hold_hlda", int'((GNT == 2'b00) || (HOLD && HLDA)), 1);
      if (GNT != 2'b00) glen++;
      else glen = 0;
      chk("inv_burst_limit", int'((glen <= MB) || !s_req[1 - m_owner]), 1);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    REQ = 2'b00;
    HLDA = 1'b0;
    tick();
    tick();
    #3;
    RESET_N = 1'b1;
  endtask

  int lat = 0;

  initial begin
    do_reset();
    chk("reset_hold",  int'(HOLD),  0);
    chk("reset_gnt",   int'(GNT),   0);
    chk("reset_busy",  int'(BUSY),  0);
    chk("reset_owner", int'(OWNER), 0);

    // Single request, HLDA three cycles after HOLD
    REQ = 2'b01; tick();
    chk("single_hold", int'(HOLD), 1);
    chk("single_busy", int'(BUSY), 1);
    tick(); tick();
    chk("single_no_gnt_yet", int'(GNT), 0);
    HLDA = 1'b1; tick();
    chk("single_gnt",   int'(GNT),   1);
    chk("single_owner", int'(OWNER), 0);
    REQ = 2'b00; tick();
    chk("single_done_gnt",  int'(GNT),  0);
    chk("single_done_hold", int'(HOLD), 0);
    chk("single_release_busy", int'(BUSY), 1);
    HLDA = 1'b0; tick();
    chk("single_idle_busy", int'(BUSY), 0);

    // Tie after reset: 0 first, then 1
    do_reset();
    REQ = 2'b11; tick();
    HLDA = 1'b1; tick();
    chk("tie_first_gnt", int'(GNT), 1);
    REQ = 2'b10; tick();
    chk("tie_rel_hold", int'(HOLD), 0);
    HLDA = 1'b0; tick();
    chk("tie_idle_busy", int'(BUSY), 0);
    tick();
    chk("tie_second_hold", int'(HOLD), 1);
    HLDA = 1'b1; tick();
    chk("tie_second_gnt",   int'(GNT),   2);
    chk("tie_second_owner", int'(OWNER), 1);
    REQ = 2'b00; tick();
    HLDA = 1'b0; tick();

    // Burst revoke at count 4
    do_reset();
    REQ = 2'b01; tick();
    HLDA = 1'b1; tick();
    chk("burst_gnt", int'(GNT), 1);
    REQ = 2'b11; tick(); tick(); tick();
    chk("burst_still_gnt", int'(GNT), 1);
    tick();
    chk("burst_revoked_gnt",  int'(GNT),  0);
    chk("burst_revoked_hold", int'(HOLD), 1);
    tick();
    chk("revoke_hold_kept", int'(HOLD), 1);
    REQ = 2'b10; tick();
    chk("revoke_hold_drop", int'(HOLD), 0);
    HLDA = 1'b0; tick();
    tick();
    HLDA = 1'b1; tick();
    chk("burst_next_gnt", int'(GNT), 2);
    REQ = 2'b00; tick();
    HLDA = 1'b0; tick();

    // Request withdrawn before HLDA
    do_reset();
    REQ = 2'b01; tick(); tick();
    REQ = 2'b00; HLDA = 1'b1; tick();
    chk("abort_gnt",  int'(GNT),  0);
    chk("abort_hold", int'(HOLD), 0);
    HLDA = 1'b0; tick();
    REQ = 2'b11; tick();
    HLDA = 1'b1; tick();
    chk("abort_ptr_kept_gnt", int'(GNT), 1);

    // Asynchronous reset mid-grant, then HLDA ignored in IDLE
    #1 RESET_N = 1'b0;
    #1;
    chk("async_rst_hold", int'(HOLD), 0);
    chk("async_rst_gnt",  int'(GNT),  0);
    REQ = 2'b00;
    tick();
    #3 RESET_N = 1'b1;
    HLDA = 1'b1;
    tick(); tick(); tick();
    chk("idle_hlda_busy", int'(BUSY), 0);
    chk("idle_hlda_hold", int'(HOLD), 0);
    chk("idle_hlda_gnt",  int'(GNT),  0);
    HLDA = 1'b0; tick();

    // Random traffic with a 1..10 cycle HLDA latency
    for (int c = 0; c < 5000; c++) begin
      for (int b = 0; b < 2; b++) begin
        if (!REQ[b]) begin
          if ($urandom_range(0, 7) == 0) REQ[b] = 1'b1;
        end else if ($urandom_range(0, 11) == 0) begin
          REQ[b] = 1'b0;
        end
      end
      if (HOLD && !HLDA) begin
        if (lat == 0) lat = $urandom_range(1, 10);
        lat--;
        if (lat == 0) HLDA = 1'b1;
      end else if (!HOLD && HLDA) begin
        lat = 0;
        if ($urandom_range(0, 1) == 0) HLDA = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
